// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I controller that sequences FETCH/DECODE/EXEC/MEM/WB with a memory watchdog and a sticky trap.
// Optional retired-instruction counter port instret_cnt is enabled by defining RV_MC_PERF_CNT_EN.
module rv32i_multicycle_ctrl #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int TIMEOUT_W    = 8,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_dbg
`ifdef RV_MC_PERF_CNT_EN
  , output logic [RETIRE_CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  localparam logic [TIMEOUT_W:0] TO_LIM = (TIMEOUT_W+1)'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  cls_t                 cls_q, cls_d, cls_dec;
  logic [1:0]           cause_q, cause_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [TIMEOUT_W:0]   wdog_nx;
  logic                 wait_cyc, timeout;

  always_comb begin
    cls_dec = C_ILL;
    case (opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_I;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BR;
      7'b1101111: cls_dec = C_JAL;
      7'b1100111: cls_dec = C_JALR;
      7'b0110111: cls_dec = C_LUI;
      7'b0010111: cls_dec = C_AUIPC;
      default:    cls_dec = C_ILL;
    endcase
  end

  // The watchdog counts the current wait cycle too, so the trap fires on the MEM_TIMEOUT-th unanswered cycle.
  assign wait_cyc = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign wdog_nx  = {1'b0, wdog_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign timeout  = (MEM_TIMEOUT != 0) && wait_cyc && (wdog_nx == TO_LIM);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        cls_d     = cls_dec;
        if (cls_dec == C_ILL) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (cls_q)
          C_R:     begin alu_src_a = 2'b01; alu_op = 2'b10; end
          C_I:     begin alu_src_a = 2'b01; alu_src_b = 2'b01; alu_op = 2'b10; end
          C_LOAD, C_STORE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            state_d   = S_MEM;
          end
          C_LUI:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
          C_AUIPC: begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
          C_BR: begin
            alu_src_a  = 2'b01;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            pc_write   = branch_taken;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          C_JAL: begin
            reg_write  = 1'b1;
            wb_sel     = 2'b10;
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          C_JALR: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b01;
            reg_write  = 1'b1;
            wb_sel     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = (cls_q == C_LOAD) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) wdog_d = '0;
    else if (wait_cyc)      wdog_d = wdog_nx[TIMEOUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_ILL;
      cause_q <= 2'b00;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      wdog_q  <= wdog_d;
    end
  end

  assign state_dbg = state_q;

`ifdef RV_MC_PERF_CNT_EN
  logic [RETIRE_CNT_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (instr_done && (state_q != S_TRAP)) begin
      instret_q <= instret_q + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: random instruction stream with memory waits plus trap, timeout and reset scenarios.
module tb_rv32i_multicycle_ctrl;
  localparam int TO = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic branch_taken = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, iord, ir_write, mdr_write, pc_write, reg_write, instr_done, trap;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, trap_cause;
  logic [2:0] state_dbg;
`ifdef RV_MC_PERF_CNT_EN
  logic [31:0] instret_cnt;
`endif

  rv32i_multicycle_ctrl #(.MEM_TIMEOUT(TO), .TIMEOUT_W(8), .RETIRE_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .mdr_write(mdr_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done),
    .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
`ifdef RV_MC_PERF_CNT_EN
    , .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [23:0] all_out = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src, alu_src_a,
                         alu_src_b, alu_op, reg_write, wb_sel, instr_done, trap, trap_cause, state_dbg};
  wire [6:0]  enables = {mem_req, mem_we, ir_write, mdr_write, pc_write, reg_write, instr_done};

  typedef struct { logic [6:0] op; int fw; int mw; bit bt; } stim_t;
  typedef struct { int lat, mreq, mwe, mdr, regw, wbsel, pcw, pcsrc; } exp_t;

  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  exp_t exp_q[$];

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Reference: cycle count and per-instruction side effects from the instruction class table.
  function automatic exp_t model(stim_t s);
    exp_t e;
    e = '{default: 0};
    e.mreq = s.fw + 1;
    e.pcw  = 1;
    case (s.op)
      OP_R, OP_I, OP_LUI, OP_AUIPC: begin e.lat = 4; e.regw = 1; e.wbsel = 0; end
      OP_LD:   begin e.lat = 5 + s.mw; e.regw = 1; e.wbsel = 1; e.mdr = 1; e.mreq += s.mw + 1; end
      OP_ST:   begin e.lat = 4 + s.mw; e.mwe = s.mw + 1; e.mreq += s.mw + 1; end
      OP_BR:   begin e.lat = 3; e.pcw += int'(s.bt); e.pcsrc = 1; end
      OP_JAL:  begin e.lat = 3; e.regw = 1; e.wbsel = 2; e.pcw += 1; e.pcsrc = 1; end
      default: begin e.lat = 3; e.regw = 1; e.wbsel = 2; e.pcw += 1; e.pcsrc = 0; end
    endcase
    e.lat += s.fw;
    return e;
  endfunction

  // Monitor: accumulates observations from FETCH entry to the retire pulse and checks them against the queue head.
  initial begin
    logic [2:0] mprev;
    int a_cyc, a_mreq, a_mwe, a_mdr, a_regw, a_wbsel, a_pcw, a_irw, retired;
    exp_t e;
    mprev = 3'd0;
    retired = 0;
    a_cyc = 0; a_mreq = 0; a_mwe = 0; a_mdr = 0; a_regw = 0; a_wbsel = 0; a_pcw = 0; a_irw = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (state_dbg == 3'd1 && mprev != 3'd1) begin
          a_cyc = 0; a_mreq = 0; a_mwe = 0; a_mdr = 0; a_regw = 0; a_wbsel = 0; a_pcw = 0; a_irw = 0;
        end
        a_cyc++;
        a_mreq += int'(mem_req);
        a_mwe  += int'(mem_we);
        a_mdr  += int'(mdr_write);
        a_regw += int'(reg_write);
        a_pcw  += int'(pc_write);
        a_irw  += int'(ir_write);
        if (reg_write) a_wbsel = int'(wb_sel);
        if (instr_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("latency", a_cyc, e.lat);
            check("mem_req_cycles", a_mreq, e.mreq);
            check("mem_we_cycles", a_mwe, e.mwe);
            check("mdr_write_pulses", a_mdr, e.mdr);
            check("reg_write_pulses", a_regw, e.regw);
            check("wb_sel", a_wbsel, e.wbsel);
            check("pc_write_pulses", a_pcw, e.pcw);
            check("pc_src_at_retire", int'(pc_src), e.pcsrc);
            check("ir_write_pulses", a_irw, 1);
          end
`ifdef RV_MC_PERF_CNT_EN
          check("instret_before_retire", int'(instret_cnt), retired);
`endif
          retired++;
        end
      end
      mprev = state_dbg;
    end
  end

  task automatic run_random(int n);
    stim_t q[$];
    stim_t cur;
    logic [6:0] legal [9];
    logic [2:0] prev, st;
    int fw_left, mw_left;
    bit fin;
    legal = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    q.push_back('{OP_R, 0, 0, 1'b0});
    q.push_back('{OP_LD, 0, 3, 1'b0});
    q.push_back('{OP_BR, 0, 0, 1'b1});
    q.push_back('{OP_BR, 0, 0, 1'b0});
    q.push_back('{OP_ST, 2, 1, 1'b0});
    for (int i = 0; i < n; i++) begin
      cur.op = legal[$urandom_range(0, 8)];
      cur.fw = $urandom_range(0, TO - 1);
      cur.mw = $urandom_range(0, TO - 1);
      cur.bt = 1'($urandom_range(0, 1));
      q.push_back(cur);
    end
    cur = q[0];
    prev = 3'd0; fin = 1'b0; fw_left = 0; mw_left = 0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(posedge clk);
      #1;
      st = state_dbg;
      if (st == 3'd1 && prev != 3'd1) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          opcode = cur.op;
          branch_taken = cur.bt;
          fw_left = cur.fw;
          exp_q.push_back(model(cur));
        end else begin
          fin = 1'b1;
        end
      end
      if (st == 3'd4 && prev != 3'd4) mw_left = cur.mw;
      if (st == 3'd1) begin
        mem_ready = !fin && (fw_left == 0);
        if (fw_left > 0) fw_left--;
      end else if (st == 3'd4) begin
        mem_ready = (mw_left == 0);
        if (mw_left > 0) mw_left--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      prev = st;
    end
    check("random_stream_finished", int'(fin), 1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    #12;
    check("reset_outputs", int'(all_out), 0);
    check("reset_state", int'(state_dbg), 0);
`ifdef RV_MC_PERF_CNT_EN
    check("reset_instret", int'(instret_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    run_random(40);
    mon_on = 1'b0;

    // Illegal opcode: sticky trap with no enables.
    #2 rst_n = 1'b0;
    mem_ready = 1'b1; opcode = 7'b0000000; branch_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (state_dbg != 3'd6 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("illegal_cycles_to_trap", n, 3);
    check("illegal_trap_flag", int'(trap), 1);
    check("illegal_trap_cause", int'(trap_cause), 1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("trap_quiet_enables", int'(enables), 0);
      check("trap_held_state", int'(state_dbg), 6);
    end
    #2 rst_n = 1'b0;
    #1;
    check("trap_cleared_flag", int'(trap), 0);
    check("trap_cleared_outputs", int'(all_out), 0);

    // Fetch timeout: no ready at all.
    mem_ready = 1'b0; opcode = OP_R; branch_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd1) n++;
      else if (state_dbg != 3'd0) break;
    end
    check("timeout_fetch_cycles", n, TO);
    check("timeout_state", int'(state_dbg), 6);
    check("timeout_cause", int'(trap_cause), 2);

    // Ready arriving on the last allowed wait cycle wins over the watchdog.
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd1) begin
        n++;
        if (n == TO) begin
          mem_ready = 1'b1;
          #1;
          check("rescue_ir_write", int'(ir_write), 1);
          check("rescue_pc_write", int'(pc_write), 1);
          break;
        end
      end
    end
    @(negedge clk);
    check("rescue_state_decode", int'(state_dbg), 2);
    check("rescue_no_trap", int'(trap), 0);

    // Let the R-type retire, then issue a store and reset it mid-MEM.
    n = 0;
    while (state_dbg != 3'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rescued_instr_retire_cycles", n, 3);
    opcode = OP_ST;
    n = 0;
    while (state_dbg != 3'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    mem_ready = 1'b0;
    #1;
    check("store_mem_req", int'(mem_req), 1);
    check("store_mem_we", int'(mem_we), 1);
    check("store_iord", int'(iord), 1);
`ifdef RV_MC_PERF_CNT_EN
    check("instret_before_reset", int'(instret_cnt), 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mem_req", int'(mem_req), 0);
    check("async_reset_mem_we", int'(mem_we), 0);
    check("async_reset_outputs", int'(all_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_release", int'(state_dbg), 0);
`ifdef RV_MC_PERF_CNT_EN
    check("instret_after_reset", int'(instret_cnt), 0);
`endif
    mem_ready = 1'b1;
    @(negedge clk);
    check("fetch_after_idle", int'(state_dbg), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
